shift_add_multiplier: RTL and testbench

//   Sequential unsigned N x N multiplier that sits directly downstream of the per-bit

---
 rtl/mult_pkg.sv | 18 +
 rtl/pp_shift_stage.sv | 20 ++
 rtl/shift_add_multiplier.sv | 101 ++++++++++
 tb/tb_shift_add_multiplier.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding, default width and
// a helper for sizing the iteration counter.
package mult_pkg;

    localparam int unsigned DefaultN = 5;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Bits needed to hold iteration indices 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w_for(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pp_shift_stage.sv
// Partial-product stage: gates operand A by one multiplier bit and shifts it into
// position within the 2N-bit accumulator width.
module pp_shift_stage #(
    parameter int unsigned N     = 5,
    parameter int unsigned CNT_W = 3
) (
    input  logic [N-1:0]     a,
    input  logic             b_bit,
    input  logic [CNT_W-1:0] index,
    output logic [2*N-1:0]   pp
);

    logic [2*N-1:0] gated;

    always_comb begin
        gated = {{N{1'b0}}, a & {N{b_bit}}};
        pp    = gated << index;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier: one partial product per cycle accumulated
// into a 2N-bit sum, with valid/ready handshakes on operands and product.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned CNT_W = cnt_w_for(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(N - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [2*N-1:0]     acc_q, acc_d;
    logic [N-1:0]       b_shifted;
    logic [2*N-1:0]     pp;

    // Select B[count] by shifting, which stays in range for any counter width.
    assign b_shifted = b_q >> count_q;

    pp_shift_stage #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_pp_shift_stage (
        .a     (a_q),
        .b_bit (b_shifted[0]),
        .index (count_q),
        .pp    (pp)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = multiplicand;
                    b_d     = multiplier;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_q + pp;
                // Test before incrementing so the counter never wraps.
                if (count_q == LastCount) begin
                    state_d = StDone;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        product   = out_valid ? acc_q : '0;
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=5): table-driven products plus
// directed backpressure, ignored-start and mid-run reset sequences.
module tb_shift_add_multiplier;

    localparam int unsigned N = 5;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp_p;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier #(
        .N     (N),
        .CNT_W (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] exp);
        checks++;
        if (actual !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, exp);
        end
    endtask

    // Called at #1 after an edge while idle; returns at #1 after the accept edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
    endtask

    // Counts edges from the accept edge (edge 1) until out_valid, bounded.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!out_valid && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " product"}, 32'(product), 32'd0);
    endtask

    initial begin
        int edges;

        vecs[0] = '{a: 5'd31, b: 5'd31, exp_p: 10'd961};
        vecs[1] = '{a: 5'd19, b: 5'd10, exp_p: 10'd190};
        vecs[2] = '{a: 5'd0,  b: 5'd27, exp_p: 10'd0};
        vecs[3] = '{a: 5'd27, b: 5'd0,  exp_p: 10'd0};
        vecs[4] = '{a: 5'd1,  b: 5'd1,  exp_p: 10'd1};
        vecs[5] = '{a: 5'd31, b: 5'd1,  exp_p: 10'd31};
        vecs[6] = '{a: 5'd16, b: 5'd16, exp_p: 10'd256};
        vecs[7] = '{a: 5'd21, b: 5'd13, exp_p: 10'd273};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d in_ready_idle", i), 32'(in_ready), 32'd1);
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d busy_run", i), 32'(busy), 32'd1);
            wait_done(edges);
            check($sformatf("v%0d latency", i), 32'(edges), 32'd6);
            check($sformatf("v%0d product", i), 32'(product), 32'(vecs[i].exp_p));
            @(posedge clk);
            #1;
            check($sformatf("v%0d back_to_back_ready", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: product and state held while out_ready is low.
        out_ready = 1'b0;
        start_op(5'd31, 5'd31);
        wait_done(edges);
        check("bp latency", 32'(edges), 32'd6);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold product c%0d", k), 32'(product), 32'd961);
            check($sformatf("bp hold in_ready c%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("bp hold out_valid c%0d", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);

        // Start attempt during RUN must be ignored.
        start_op(5'd7, 5'd9);
        @(posedge clk);
        #1;
        in_valid     = 1'b1;
        multiplicand = 5'd3;
        multiplier   = 5'd3;
        check("ignore in_ready_run", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges    = 3;
        while (!out_valid && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("ignore latency", 32'(edges), 32'd6);
        check("ignore product", 32'(product), 32'd63);
        @(posedge clk);
        #1;

        // Reset asserted while RUN has count=2.
        start_op(5'd31, 5'd31);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post reset");
        start_op(5'd6, 5'd5);
        wait_done(edges);
        check("post reset latency", 32'(edges), 32'd6);
        check("post reset product", 32'(product), 32'd30);

        // Reset asserted while DONE is being held.
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("middone reset");
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
